// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
//
// Owns the PC and fetches from a variable-latency instruction memory. The fetched
// instruction, its PC and PC+PC_INC are presented to decode through IF/ID.
// `stall` freezes the PC and IF/ID. A response that arrives during a stall is
// parked in a one-entry hold buffer. `redirect_valid` loads a new PC and flushes
// IF/ID to a bubble. If the redirect abandons an outstanding request, that
// response is drained and dropped in StDiscard.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   stall               hold PC and IF/ID
//   redirect_valid/pc   taken branch/jump target (one-cycle pulse)
//   imem_req/addr       request to instruction memory
//   imem_ready/data     response valid / fetched instruction
//   if_id_valid/instr/pc/pc_plus4  IF/ID register outputs to decode
module fetch_stage #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0000_1000,
    parameter int unsigned          PC_INC   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_plus4
);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    localparam logic [ADDR_W-1:0] Inc = ADDR_W'(PC_INC);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   disc_addr_q, disc_addr_d;
    logic                hold_valid_q, hold_valid_d;
    logic [INSTR_W-1:0]  hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;
    logic                if_id_valid_q, if_id_valid_d;
    logic [INSTR_W-1:0]  if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]   if_id_pc_q, if_id_pc_d;
    logic [ADDR_W-1:0]   if_id_pc_plus4_q, if_id_pc_plus4_d;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        disc_addr_d      = disc_addr_q;
        hold_valid_d     = hold_valid_q;
        hold_instr_d     = hold_instr_q;
        hold_pc_d        = hold_pc_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;

        // A parked response suppresses new requests until decode takes it.
        imem_req  = ((state_q == StReq) && !hold_valid_q) || (state_q == StDiscard);
        // In StDiscard pc_q already holds the redirect target, so the stale address is replayed.
        imem_addr = (state_q == StDiscard) ? disc_addr_q : pc_q;

        if (redirect_valid) begin
            pc_d          = redirect_pc;
            if_id_valid_d = 1'b0;
            hold_valid_d  = 1'b0;
            if (imem_req && !imem_ready) begin
                state_d = StDiscard;
                if (state_q == StReq) disc_addr_d = pc_q;
            end else begin
                state_d = StReq;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StReq;
                    if (!stall) if_id_valid_d = 1'b0;
                end
                StReq: begin
                    if (hold_valid_q) begin
                        if (!stall) begin
                            if_id_valid_d    = 1'b1;
                            if_id_instr_d    = hold_instr_q;
                            if_id_pc_d       = hold_pc_q;
                            if_id_pc_plus4_d = hold_pc_q + Inc;
                            hold_valid_d     = 1'b0;
                        end
                    end else if (imem_ready) begin
                        pc_d = pc_q + Inc;
                        if (stall) begin
                            hold_valid_d = 1'b1;
                            hold_instr_d = imem_data;
                            hold_pc_d    = pc_q;
                        end else begin
                            if_id_valid_d    = 1'b1;
                            if_id_instr_d    = imem_data;
                            if_id_pc_d       = pc_q;
                            if_id_pc_plus4_d = pc_q + Inc;
                        end
                    end else if (!stall) begin
                        if_id_valid_d = 1'b0;
                    end
                end
                StDiscard: begin
                    if (imem_ready) state_d = StReq;
                    if (!stall) if_id_valid_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            pc_q             <= RESET_PC;
            disc_addr_q      <= RESET_PC;
            hold_valid_q     <= 1'b0;
            hold_instr_q     <= '0;
            hold_pc_q        <= '0;
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= '0;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            disc_addr_q      <= disc_addr_d;
            hold_valid_q     <= hold_valid_d;
            hold_instr_q     <= hold_instr_d;
            hold_pc_q        <= hold_pc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a wait-state memory model feeds the DUT, expected IF/ID
// contents are queued when a response is delivered and compared when loaded.
// A second instance with RESET_PC at the top of the address space checks wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;

    int n_checks = 0;
    int n_errors = 0;
    int waits = 0;
    int wait_cnt = 0;
    bit discarding = 1'b0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ready     (1'b1),
        .imem_data      (32'h0000_0013),
        .if_id_valid    (w_valid),
        .if_id_instr    (w_instr),
        .if_id_pc       (w_pc),
        .if_id_pc_plus4 (w_pc4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        imem_ready = 1'b0;
        sb.delete();
        discarding = 1'b0;
        wait_cnt = 0;
        @(posedge clk);
        #1;
        check_eq("rst_req", {31'b0, imem_req}, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0000_1000);
        check_eq("rst_valid", {31'b0, if_id_valid}, 32'h0);
        check_eq("rst_instr", if_id_instr, 32'h0);
        check_eq("rst_pc", if_id_pc, 32'h0);
        check_eq("rst_pc4", if_id_pc_plus4, 32'h0);
        rst_n = 1'b1;
    endtask

    // One clock: memory model answers the current request, scoreboard is updated,
    // then IF/ID is compared if it was loaded at this edge.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
        logic rdy;
        logic [63:0] e;
        rdy = 1'b0;
        if (imem_req) begin
            if (wait_cnt == waits) begin
                rdy = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        stall = st;
        redirect_valid = rd;
        redirect_pc = rpc;
        imem_ready = rdy;
        imem_data = mem_word(imem_addr);
        if (rdy && !rd && !discarding) sb.push_back({imem_addr, mem_word(imem_addr)});
        if (rd) discarding = imem_req && !rdy;
        else if (rdy) discarding = 1'b0;
        @(posedge clk);
        #1;
        if ((!st || rd) && if_id_valid) begin
            check_eq("sb_has_entry", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("sb_pc", if_id_pc, e[63:32]);
                check_eq("sb_instr", if_id_instr, e[31:0]);
                check_eq("sb_pc4", if_id_pc_plus4, e[63:32] + 32'd4);
            end
        end
    endtask

    initial begin
        // Zero-wait memory, plus wrap instance.
        waits = 0;
        apply_reset();
        check_eq("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0);
        check_eq("zw_req", {31'b0, imem_req}, 32'h1);
        check_eq("zw_addr0", imem_addr, 32'h0000_1000);
        check_eq("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0);
        check_eq("zw_addr1", imem_addr, 32'h0000_1004);
        check_eq("zw_valid1", {31'b0, if_id_valid}, 32'h1);
        check_eq("wrap_addr1", w_addr, 32'h0000_0000);
        check_eq("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", w_pc4, 32'h0000_0000);
        tick(0, 0, 0);
        check_eq("zw_addr2", imem_addr, 32'h0000_1008);
        check_eq("zw_valid2", {31'b0, if_id_valid}, 32'h1);
        check_eq("wrap_addr2", w_addr, 32'h0000_0004);
        tick(0, 0, 0);
        check_eq("zw_drain", 32'(sb.size()), 32'h0);

        // Two wait states.
        waits = 2;
        apply_reset();
        tick(0, 0, 0);
        tick(0, 0, 0);
        check_eq("ws_addr_a", imem_addr, 32'h0000_1000);
        check_eq("ws_bubble_a", {31'b0, if_id_valid}, 32'h0);
        tick(0, 0, 0);
        check_eq("ws_addr_b", imem_addr, 32'h0000_1000);
        check_eq("ws_bubble_b", {31'b0, if_id_valid}, 32'h0);
        tick(0, 0, 0);
        check_eq("ws_valid", {31'b0, if_id_valid}, 32'h1);
        check_eq("ws_next_addr", imem_addr, 32'h0000_1004);
        check_eq("ws_drain", 32'(sb.size()), 32'h0);

        // Stall with a response parked in the hold buffer.
        waits = 0;
        apply_reset();
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check_eq("st_pre_pc", if_id_pc, 32'h0000_1004);
        check_eq("st_pre_addr", imem_addr, 32'h0000_1008);
        tick(1, 0, 0);
        check_eq("st_hold_pc_a", if_id_pc, 32'h0000_1004);
        check_eq("st_hold_valid_a", {31'b0, if_id_valid}, 32'h1);
        check_eq("st_req_a", {31'b0, imem_req}, 32'h0);
        tick(1, 0, 0);
        check_eq("st_hold_pc_b", if_id_pc, 32'h0000_1004);
        check_eq("st_req_b", {31'b0, imem_req}, 32'h0);
        tick(0, 0, 0);
        check_eq("st_release_pc", if_id_pc, 32'h0000_1008);
        check_eq("st_req_resume", {31'b0, imem_req}, 32'h1);
        check_eq("st_next_addr", imem_addr, 32'h0000_100C);
        tick(0, 0, 0);
        check_eq("st_drain", 32'(sb.size()), 32'h0);

        // Redirect while a 3-wait-state request is outstanding.
        waits = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        check_eq("rd_pre_addr", imem_addr, 32'h0000_1010);
        waits = 3;
        tick(0, 0, 0);
        tick(0, 1, 32'h0000_2000);
        check_eq("rd_flush", {31'b0, if_id_valid}, 32'h0);
        check_eq("rd_disc_addr", imem_addr, 32'h0000_1010);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check_eq("rd_new_addr", imem_addr, 32'h0000_2000);
        check_eq("rd_disc_bubble", {31'b0, if_id_valid}, 32'h0);
        waits = 0;
        tick(0, 0, 0);
        check_eq("rd_first_pc", if_id_pc, 32'h0000_2000);
        check_eq("rd_drain", 32'(sb.size()), 32'h0);

        // Redirect and stall together: redirect wins.
        waits = 0;
        apply_reset();
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(1, 1, 32'h0000_3000);
        check_eq("rs_flush", {31'b0, if_id_valid}, 32'h0);
        check_eq("rs_addr", imem_addr, 32'h0000_3000);
        tick(0, 0, 0);
        check_eq("rs_first_pc", if_id_pc, 32'h0000_3000);
        check_eq("rs_drain", 32'(sb.size()), 32'h0);

        // Reset during a wait state.
        waits = 2;
        apply_reset();
        tick(0, 0, 0);
        tick(0, 0, 0);
        check_eq("mr_pending_req", {31'b0, imem_req}, 32'h1);
        apply_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
